// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencing controller: FSM encoding and
// default scoreboard geometry.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        BR_WAIT = 2'b01,
        HALT    = 2'b10
    } fetch_state_e;

    localparam int NUM_REGS_DEF = 8;
    localparam int REG_W_DEF    = 3;
    localparam int CNT_W_DEF    = 3;

endpackage : fetch_ctrl_pkg

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters. Saturating increment / floor-at-zero
// decrement; err pulses in any cycle an overflow or underflow is attempted.
module reg_scoreboard
    import fetch_ctrl_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int REG_W    = REG_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             incEn,
    input  logic [REG_W-1:0] incReg,
    input  logic             decEn,
    input  logic [REG_W-1:0] decReg,
    input  logic [REG_W-1:0] rd1Reg,
    input  logic [REG_W-1:0] rd2Reg,
    output logic             busy1,
    output logic             busy2,
    output logic             err
);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            incHit, decHit, ovf, unf;

    for (genvar i = 0; i < NUM_REGS; i++) begin : gDec
        assign incHit[i] = incEn && (incReg == REG_W'(i));
        assign decHit[i] = decEn && (decReg == REG_W'(i));
        // Simultaneous inc and dec on one register cancel out, never an error.
        assign ovf[i]    = incHit[i] && !decHit[i] && (cnt[i] == '1);
        assign unf[i]    = decHit[i] && !incHit[i] && (cnt[i] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (incHit[i] && !decHit[i] && !ovf[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (decHit[i] && !incHit[i] && !unf[i])
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    // Read ports see pre-update counts, so a same-cycle retire still stalls.
    assign busy1 = |cnt[rd1Reg];
    assign busy2 = |cnt[rd2Reg];
    assign err   = |(ovf | unf);

endmodule : reg_scoreboard

// File: rtl/fetch_issue_ctrl.sv
// Fetch-stage sequencer: RAW stall via pending-write scoreboard, branch
// shadow wait, and terminal HALT. Drives PC write-enable and NOP-select.
module fetch_issue_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int REG_W    = REG_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid,
    input  logic             src1_use,
    input  logic [REG_W-1:0] src1_reg,
    input  logic             src2_use,
    input  logic [REG_W-1:0] src2_reg,
    input  logic             dst_wr,
    input  logic [REG_W-1:0] dst_reg,
    input  logic             is_branch,
    input  logic             is_halt,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_reg,
    input  logic             br_resolve,
    output logic             pc_we,
    output logic             nop_sel,
    output logic             issue,
    output logic             halted,
    output logic             err
);

    fetch_state_e state, stateNxt;
    logic         busy1, busy2, hazard, sbErr, protoErr;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W),
        .CNT_W    (CNT_W)
    ) uScoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .incEn  (issue && dst_wr),
        .incReg (dst_reg),
        .decEn  (wb_valid),
        .decReg (wb_reg),
        .rd1Reg (src1_reg),
        .rd2Reg (src2_reg),
        .busy1  (busy1),
        .busy2  (busy2),
        .err    (sbErr)
    );

    assign hazard   = inst_valid && ((src1_use && busy1) || (src2_use && busy2));
    assign protoErr = br_resolve && (state != BR_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        unique case (state)
            RUN: begin
                if (issue) begin
                    if (is_halt)        stateNxt = HALT;
                    else if (is_branch) stateNxt = BR_WAIT;
                end
            end
            BR_WAIT: if (br_resolve) stateNxt = RUN;
            HALT:    stateNxt = HALT;
            default: stateNxt = RUN;
        endcase
    end

    always_comb begin
        pc_we   = 1'b0;
        nop_sel = 1'b1;
        issue   = 1'b0;
        halted  = 1'b0;
        unique case (state)
            RUN: begin
                if (!inst_valid) begin
                    pc_we = 1'b1;
                end else if (!hazard) begin
                    pc_we   = 1'b1;
                    nop_sel = 1'b0;
                    issue   = 1'b1;
                end
            end
            // PC loads the resolved target in the resolve cycle.
            BR_WAIT: pc_we  = br_resolve;
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    err <= 1'b0;
        else if (sbErr || protoErr)    err <= 1'b1;
    end

endmodule : fetch_issue_ctrl

// File: tb/tb_fetch_issue_ctrl.sv
// Directed bench for fetch_issue_ctrl; expected outputs are queued per step
// and popped when the combinational outputs are sampled mid-cycle.
module tb_fetch_issue_ctrl;
    import fetch_ctrl_pkg::*;

    typedef struct packed {
        logic       iv;
        logic       s1u;
        logic [2:0] s1r;
        logic       s2u;
        logic [2:0] s2r;
        logic       dw;
        logic [2:0] dr;
        logic       br;
        logic       ht;
        logic       wbv;
        logic [2:0] wbr;
        logic       brr;
    } in_t;

    typedef struct packed {
        logic pcWe;
        logic nopSel;
        logic issue;
        logic halted;
        logic err;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       inst_valid, src1_use, src2_use, dst_wr, is_branch, is_halt;
    logic       wb_valid, br_resolve;
    logic [2:0] src1_reg, src2_reg, dst_reg, wb_reg;
    logic       pc_we, nop_sel, issue, halted, err;

    exp_t  expQ[$];
    string tagQ[$];
    int    testCnt = 0, failCnt = 0;

    fetch_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_valid (inst_valid),
        .src1_use   (src1_use),
        .src1_reg   (src1_reg),
        .src2_use   (src2_use),
        .src2_reg   (src2_reg),
        .dst_wr     (dst_wr),
        .dst_reg    (dst_reg),
        .is_branch  (is_branch),
        .is_halt    (is_halt),
        .wb_valid   (wb_valid),
        .wb_reg     (wb_reg),
        .br_resolve (br_resolve),
        .pc_we      (pc_we),
        .nop_sel    (nop_sel),
        .issue      (issue),
        .halted     (halted),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic p, logic n, logic i, logic h, logic e);
        exp_t r;
        r.pcWe = p; r.nopSel = n; r.issue = i; r.halted = h; r.err = e;
        return r;
    endfunction

    task automatic apply(input in_t x);
        inst_valid = x.iv;  src1_use = x.s1u; src1_reg = x.s1r;
        src2_use   = x.s2u; src2_reg = x.s2r; dst_wr   = x.dw;
        dst_reg    = x.dr;  is_branch = x.br; is_halt  = x.ht;
        wb_valid   = x.wbv; wb_reg   = x.wbr; br_resolve = x.brr;
    endtask

    task automatic check();
        exp_t  e, got;
        string t;
        e   = expQ.pop_front();
        t   = tagQ.pop_front();
        got = mk(pc_we, nop_sel, issue, halted, err);
        testCnt++;
        assert (got === e) else begin
            failCnt++;
            $error("FAIL %s: observed {pc_we,nop_sel,issue,halted,err}=%b expected %b", t, got, e);
        end
    endtask

    // One clock: drive at negedge, sample 2 time units later, edge follows.
    task automatic step(input in_t x, input exp_t e, input string tag);
        @(negedge clk);
        apply(x);
        expQ.push_back(e);
        tagQ.push_back(tag);
        #2 check();
    endtask

    task automatic doReset();
        in_t z;
        z = '0;
        @(negedge clk);
        rst_n = 1'b0;
        apply(z);
        expQ.push_back(mk(1, 1, 0, 0, 0));
        tagQ.push_back("reset");
        #2 check();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        in_t x;
        x = '0;
        apply(x);
        doReset();

        // Issue a writer of r3, then RAW stall on r3 until retire.
        x = '0; x.iv = 1; x.dw = 1; x.dr = 3;
        step(x, mk(1, 0, 1, 0, 0), "issue_w3");
        x = '0; x.iv = 1; x.s1u = 1; x.s1r = 3;
        for (int i = 0; i < 3; i++) step(x, mk(0, 1, 0, 0, 0), "raw_stall_r3");
        x.wbv = 1; x.wbr = 3;
        step(x, mk(0, 1, 0, 0, 0), "stall_on_retire_cycle");
        x.wbv = 0;
        step(x, mk(1, 0, 1, 0, 0), "issue_after_retire");

        // src2 hazard path.
        x = '0; x.iv = 1; x.dw = 1; x.dr = 4;
        step(x, mk(1, 0, 1, 0, 0), "issue_w4");
        x = '0; x.iv = 1; x.s2u = 1; x.s2r = 4; x.s1r = 4;
        step(x, mk(0, 1, 0, 0, 0), "raw_stall_src2");
        x = '0; x.wbv = 1; x.wbr = 4;
        step(x, mk(1, 1, 0, 0, 0), "idle_retire_r4");
        x = '0; x.iv = 1; x.s2u = 1; x.s2r = 4;
        step(x, mk(1, 0, 1, 0, 0), "issue_src2_clear");

        // Branch shadow.
        x = '0; x.iv = 1; x.br = 1;
        step(x, mk(1, 0, 1, 0, 0), "issue_branch");
        x = '0; x.iv = 1;
        for (int i = 0; i < 4; i++) step(x, mk(0, 1, 0, 0, 0), "br_wait");
        x.brr = 1;
        step(x, mk(1, 1, 0, 0, 0), "br_resolve_cycle");
        x.brr = 0;
        step(x, mk(1, 0, 1, 0, 0), "run_after_resolve");

        // Same-register inc and dec cancel.
        x = '0; x.iv = 1; x.dw = 1; x.dr = 5;
        step(x, mk(1, 0, 1, 0, 0), "issue_w5");
        x.wbv = 1; x.wbr = 5;
        step(x, mk(1, 0, 1, 0, 0), "issue_w5_with_retire5");
        x = '0; x.iv = 1; x.s1u = 1; x.s1r = 5;
        step(x, mk(0, 1, 0, 0, 0), "r5_still_pending");
        x = '0; x.wbv = 1; x.wbr = 5;
        step(x, mk(1, 1, 0, 0, 0), "retire_r5_no_err");
        x = '0; x.iv = 1; x.s1u = 1; x.s1r = 5;
        step(x, mk(1, 0, 1, 0, 0), "r5_clear_no_err");

        // Underflow sets sticky err.
        x = '0; x.wbv = 1; x.wbr = 2;
        step(x, mk(1, 1, 0, 0, 0), "underflow_cycle");
        x = '0;
        step(x, mk(1, 1, 0, 0, 1), "err_after_underflow");
        step(x, mk(1, 1, 0, 0, 1), "err_sticky");

        // Stray br_resolve in RUN.
        doReset();
        x = '0; x.brr = 1;
        step(x, mk(1, 1, 0, 0, 0), "stray_resolve_cycle");
        x = '0;
        step(x, mk(1, 1, 0, 0, 1), "err_after_stray_resolve");

        // Saturation at 7 pending writes on r6.
        doReset();
        x = '0; x.iv = 1; x.dw = 1; x.dr = 6;
        for (int i = 0; i < 8; i++) step(x, mk(1, 0, 1, 0, 0), "issue_w6");
        x = '0; x.iv = 1; x.s1u = 1; x.s1r = 6;
        step(x, mk(0, 1, 0, 0, 1), "err_after_overflow");
        x = '0; x.wbv = 1; x.wbr = 6;
        for (int i = 0; i < 7; i++) step(x, mk(1, 1, 0, 0, 1), "drain_r6");
        x = '0; x.iv = 1; x.s1u = 1; x.s1r = 6;
        step(x, mk(1, 0, 1, 0, 1), "r6_drained_at_7");

        // HALT with retirement continuing, then reset mid-HALT.
        doReset();
        x = '0; x.iv = 1; x.dw = 1; x.dr = 1;
        step(x, mk(1, 0, 1, 0, 0), "issue_w1_a");
        step(x, mk(1, 0, 1, 0, 0), "issue_w1_b");
        x = '0; x.iv = 1; x.ht = 1; x.br = 1;
        step(x, mk(1, 0, 1, 0, 0), "issue_halt");
        x = '0; x.iv = 1;
        step(x, mk(0, 1, 0, 1, 0), "halted");
        x = '0; x.iv = 1; x.wbv = 1; x.wbr = 1;
        step(x, mk(0, 1, 0, 1, 0), "halt_retire_1");
        step(x, mk(0, 1, 0, 1, 0), "halt_retire_2");
        step(x, mk(0, 1, 0, 1, 0), "halt_underflow_cycle");
        x = '0;
        step(x, mk(0, 1, 0, 1, 1), "halt_err_proves_retire");
        doReset();
        x = '0; x.iv = 1; x.s1u = 1; x.s1r = 1; x.s2u = 1; x.s2r = 6;
        step(x, mk(1, 0, 1, 0, 0), "scoreboard_empty_after_reset");

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule : tb_fetch_issue_ctrl

// File: doc/fetch_issue_ctrl.md
Name: fetch_issue_ctrl

Overview:
- Sequencing controller for the fetch stage.
- Decides each cycle whether the PC register advances and whether the fetched instruction is forwarded or replaced by a NOP.
- Uses a per-register pending-write scoreboard for RAW hazards, a branch-shadow wait for control hazards, and a halt state.
- Sits between instruction memory output and the fetch/decode pipeline register; drives PC write-enable and NOP-select.

Parameters:
- NUM_REGS, 8, architectural registers tracked.
- REG_W, 3, register-index width (clog2 of NUM_REGS).
- CNT_W, 3, pending-write counter width per register (max 7 in flight).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid  in  1  fetched instruction valid this cycle.
- src1_use  in  1  instruction reads src1.
- src1_reg  in  REG_W  source register 1.
- src2_use  in  1  instruction reads src2.
- src2_reg  in  REG_W  source register 2.
- dst_wr  in  1  instruction writes a register.
- dst_reg  in  REG_W  destination register.
- is_branch  in  1  instruction is branch/jump.
- is_halt  in  1  instruction is HALT.
- wb_valid  in  1  writeback retiring a register write.
- wb_reg  in  REG_W  register retired.
- br_resolve  in  1  execute resolved outstanding branch (1-cycle pulse).
- pc_we  out  1  PC register write enable.
- nop_sel  out  1  replace fetched instruction with NOP.
- issue  out  1  instruction accepted into decode this cycle.
- halted  out  1  controller in HALT.
- err  out  1  sticky scoreboard overflow/underflow/protocol error.

Behaviour:
- Reset (async, rst_n=0): state=RUN, all counters 0, err=0. Outputs then: pc_we=1, nop_sel=1 when inst_valid=0, issue=0, halted=0.
- hazard = inst_valid & ((src1_use & cnt[src1_reg]!=0) | (src2_use & cnt[src2_reg]!=0)).
- Outputs are combinational from state and inputs. State and counters update on the rising edge of clk.
- RUN:
  - No inst_valid: pc_we=1, nop_sel=1, issue=0.
  - hazard: pc_we=0, nop_sel=1, issue=0; stay in RUN. This is the RAW stall; it re-evaluates each cycle, with no separate stall state.
  - Otherwise issue=1, pc_we=1, nop_sel=0.
  - After issue: is_branch goes to BR_WAIT; is_halt goes to HALT (is_halt has priority if both are set).
- BR_WAIT: pc_we=0, nop_sel=1, issue=0 until br_resolve. In the br_resolve cycle, pc_we=1 (newPC carries the resolved target) and the next state is RUN.
- HALT: pc_we=0, nop_sel=1, halted=1. Leaves only on reset.
- Scoreboard counters:
  - issue & dst_wr increments cnt[dst_reg].
  - wb_valid decrements cnt[wb_reg].
  - Both on the same register in the same cycle: count unchanged.
  - Retirement continues in every state, including HALT and BR_WAIT.
- Same-cycle retire vs. hazard check: the hazard check uses pre-update counts. A register retiring this cycle still stalls, and the instruction issues next cycle.
- Increment at all-ones: counter saturates, err=1.
- Decrement at 0: counter stays 0, err=1.
- br_resolve outside BR_WAIT: ignored, err=1.
- err is sticky until reset.
- Reset mid-stall or mid-branch: returns to RUN with an empty scoreboard.

Decomposition:
- Shared package fetch_ctrl_pkg holds:
  - state encoding: RUN=2'b00, BR_WAIT=2'b01, HALT=2'b10;
  - NUM_REGS, REG_W, CNT_W defaults.
- Sub-module reg_scoreboard holds the NUM_REGS×CNT_W counter array. It provides inc/dec ports, two read ports (busy1, busy2) and an err output.
- The FSM and output logic stay in fetch_issue_ctrl.

Test Plan:
- Reset then inst_valid=1, no uses, dst_wr=1, dst_reg=3 -> issue=1, pc_we=1, nop_sel=0; cnt[3]=1 next cycle.
- Then src1_use=1, src1_reg=3 with wb_valid=0 for 3 cycles -> pc_we=0, nop_sel=1 for 3 cycles.
  - Pulse wb_valid, wb_reg=3 -> still stalled that cycle; issue=1 the following cycle.
- Issue with is_branch=1 -> BR_WAIT, pc_we=0, nop_sel=1 for 4 cycles; br_resolve pulse -> pc_we=1 that cycle, RUN next.
- Issue dst_wr=1, dst_reg=5 with simultaneous wb_valid=1, wb_reg=5 while cnt[5]=1 -> cnt[5] stays 1, err=0.
- wb_valid=1, wb_reg=2 with cnt[2]=0 -> err=1 and stays 1. Separately, br_resolve in RUN -> err=1.
- Issue is_halt=1 -> halted=1, pc_we=0 permanently; wb_valid still decrements. Assert rst_n=0 mid-HALT -> halted=0, counters 0 immediately.
